// File: rtl/c17_pipe_checker.sv
// Response monitor for the pipelined c17 netlists: golden c17 model, LATENCY-deep
// delay line, compare against the DUT outputs, counters and verdict FSM.
// Optional first-failure capture is enabled by defining C17_CHK_CAPTURE_EN.
module c17_pipe_checker #(
  parameter int LATENCY = 3,  // legal range 1..8
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  input  logic             N1,
  input  logic             N2,
  input  logic             N3,
  input  logic             N6,
  input  logic             N7,
  input  logic             dut_N22,
  input  logic             dut_N23,
  input  logic             flush,
  input  logic             clear,
  output logic             exp_N22,
  output logic             exp_N23,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             done,
  output logic             pass,
  output logic [4:0]       ff_vec,
  output logic [1:0]       ff_obs
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic       valid;
    logic       n22;
    logic       n23;
`ifdef C17_CHK_CAPTURE_EN
    logic [4:0] vec;
`endif
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  entry_t           line_q [LATENCY];
  entry_t           head_d;
  entry_t           tail;
  logic             accept;
  logic             any_valid;
  logic             cmp_fail;
  logic             mismatch_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             n10, n11, n16, n19, gold_n22, gold_n23;

  assign n10      = ~(N1 & N3);
  assign n11      = ~(N3 & N6);
  assign n16      = ~(N2 & n11);
  assign n19      = ~(n11 & N7);
  assign gold_n22 = ~(n10 & n16);
  assign gold_n23 = ~(n16 & n19);

  // Vectors are only taken before the stimulus has been flushed; clear blocks them.
  assign accept = vec_valid && !clear && (state_q == S_IDLE || state_q == S_RUN);

  assign tail     = line_q[LATENCY-1];
  assign cmp_fail = tail.valid && ({tail.n22, tail.n23} != {dut_N22, dut_N23});

  assign vec_count_d = (vec_count_q == '1) ? vec_count_q : vec_count_q + CNT_ONE;
  assign err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + CNT_ONE;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    head_d    = '0;
    any_valid = 1'b0;
    if (accept) begin
      head_d.valid = 1'b1;
      head_d.n22   = gold_n22;
      head_d.n23   = gold_n23;
`ifdef C17_CHK_CAPTURE_EN
      head_d.vec   = {N1, N2, N3, N6, N7};
`endif
    end
    for (int i = 0; i < LATENCY; i++) any_valid = any_valid | line_q[i].valid;
  end

`ifdef C17_CHK_CAPTURE_EN
  logic [4:0] ff_vec_q;
  logic [1:0] ff_obs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vec_q <= '0;
      ff_obs_q <= '0;
    end else if (clear) begin
      ff_vec_q <= '0;
      ff_obs_q <= '0;
    end else if (cmp_fail && err_count_q == '0) begin
      // The error counter never returns to zero without clear, so this is the first failure.
      ff_vec_q <= tail.vec;
      ff_obs_q <= {dut_N22, dut_N23};
    end
  end

  assign ff_vec = ff_vec_q;
  assign ff_obs = ff_obs_q;
`else
  assign ff_vec = '0;
  assign ff_obs = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the delay line is plain flops, not RAM; every entry is reset so no stale valid bit survives.
      for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
      state_q     <= S_IDLE;
      vec_count_q <= '0;
      err_count_q <= '0;
      mismatch_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
      state_q     <= S_IDLE;
      vec_count_q <= '0;
      err_count_q <= '0;
      mismatch_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the shift read the pre-edge contents of each entry.
      line_q[0] <= head_d;
      for (int i = 1; i < LATENCY; i++) line_q[i] <= line_q[i-1];
      mismatch_q <= cmp_fail;
      if (tail.valid) begin
        vec_count_q <= vec_count_d;
        if (cmp_fail) err_count_q <= err_count_d;
      end

      unique case (state_q)
        S_IDLE: begin
          if (flush) begin
            if (accept) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end else if (accept) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Line empty before this edge means the last compare has already happened.
          if (!any_valid) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_count_q == '0);
          end
        end
        default: state_q <= S_DONE;
      endcase
    end
  end

  assign exp_N22   = tail.n22;
  assign exp_N23   = tail.n23;
  assign mismatch  = mismatch_q;
  assign vec_count = vec_count_q;
  assign err_count = err_count_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_c17_pipe_checker.sv
// Bench for c17_pipe_checker: a pipelined stand-in DUT with fault injection, a
// queue-based reference model compared every cycle, and directed scenarios.
module tb_c17_pipe_checker;

  localparam int LAT = 3;
`ifdef C17_CHK_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vec_valid = 1'b0, flush = 1'b0, clear = 1'b0;
  logic [4:0] vec = 5'b0;  // {N1,N2,N3,N6,N7}
  logic       fault22 = 1'b0, stuck = 1'b0;
  logic       dut_N22, dut_N23;

  logic        exp22, exp23, mis, done, pass;
  logic [15:0] vcnt, ecnt;
  logic [4:0]  ffv;
  logic [1:0]  ffo;
  logic        s_exp22, s_exp23, s_mis, s_done, s_pass;
  logic [1:0]  s_vcnt, s_ecnt;
  logic [4:0]  s_ffv;
  logic [1:0]  s_ffo;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  c17_pipe_checker #(.LATENCY(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .vec_valid(vec_valid),
    .N1(vec[4]), .N2(vec[3]), .N3(vec[2]), .N6(vec[1]), .N7(vec[0]),
    .dut_N22(dut_N22), .dut_N23(dut_N23), .flush(flush), .clear(clear),
    .exp_N22(exp22), .exp_N23(exp23), .mismatch(mis), .vec_count(vcnt),
    .err_count(ecnt), .done(done), .pass(pass), .ff_vec(ffv), .ff_obs(ffo)
  );

  c17_pipe_checker #(.LATENCY(LAT), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .vec_valid(vec_valid),
    .N1(vec[4]), .N2(vec[3]), .N3(vec[2]), .N6(vec[1]), .N7(vec[0]),
    .dut_N22(dut_N22), .dut_N23(dut_N23), .flush(flush), .clear(clear),
    .exp_N22(s_exp22), .exp_N23(s_exp23), .mismatch(s_mis), .vec_count(s_vcnt),
    .err_count(s_ecnt), .done(s_done), .pass(s_pass), .ff_vec(s_ffv), .ff_obs(s_ffo)
  );

  function automatic logic [1:0] golden(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[4] & v[2]);
    n11 = ~(v[2] & v[1]);
    n16 = ~(v[3] & n11);
    n19 = ~(n11 & v[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic int sat(input int x, input int w);
    int top;
    top = (1 << w) - 1;
    return (x > top) ? top : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Stand-in pipelined DUT: vector seen at edge k appears at its outputs for edge k+LAT.
  logic [1:0] pipe [LAT] = '{default: 2'b00};
  always @(posedge clk) begin
    pipe[0] <= stuck ? 2'b11 : (golden(vec) | {fault22, 1'b0});
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dut_N22 = pipe[LAT-1][1];
  assign dut_N23 = pipe[LAT-1][0];

  // Reference model: each accepted vector waits in a queue until its due edge.
  typedef struct { int due; logic [1:0] gold; logic [4:0] v; } pend_t;
  pend_t      pq[$];
  pend_t      cur;
  int         cyc = 0, m_vec = 0, m_err = 0, phase = P_IDLE;
  logic       m_mis = 1'b0, m_done = 1'b0, m_pass = 1'b0;
  logic [4:0] m_ffv = 5'b0;
  logic [1:0] m_ffo = 2'b0;
  bit         was_empty, acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pq.delete();
      cyc = 0; m_vec = 0; m_err = 0; phase = P_IDLE;
      m_mis = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_ffv = '0; m_ffo = '0;
    end else begin
      cyc++;
      m_mis = 1'b0;
      if (clear) begin
        pq.delete();
        m_vec = 0; m_err = 0; phase = P_IDLE;
        m_done = 1'b0; m_pass = 1'b0; m_ffv = '0; m_ffo = '0;
      end else begin
        was_empty = (pq.size() == 0);
        if (!was_empty && pq[0].due == cyc) begin
          cur = pq.pop_front();
          m_vec++;
          if (cur.gold != {dut_N22, dut_N23}) begin
            if (m_err == 0 && CAP) begin
              m_ffv = cur.v;
              m_ffo = {dut_N22, dut_N23};
            end
            m_err++;
            m_mis = 1'b1;
          end
        end
        acc = vec_valid && (phase == P_IDLE || phase == P_RUN);
        if (acc) pq.push_back('{due: cyc + LAT, gold: golden(vec), v: vec});
        case (phase)
          P_IDLE: begin
            if (flush) begin
              if (acc) phase = P_DRAIN;
              else begin phase = P_DONE; m_done = 1'b1; m_pass = 1'b1; end
            end else if (acc) phase = P_RUN;
          end
          P_RUN:   if (flush) phase = P_DRAIN;
          P_DRAIN: if (was_empty) begin phase = P_DONE; m_done = 1'b1; m_pass = (m_err == 0); end
          default: ;
        endcase
      end
    end
  end

  logic [1:0] ee;
  always @(negedge clk) begin
    ee = (pq.size() > 0 && pq[0].due == cyc + 1) ? pq[0].gold : 2'b00;
    check("exp", 32'({exp22, exp23}), 32'(ee));
    check("s_exp", 32'({s_exp22, s_exp23}), 32'(ee));
    check("mismatch", 32'(mis), 32'(m_mis));
    check("s_mismatch", 32'(s_mis), 32'(m_mis));
    check("vec_count", 32'(vcnt), sat(m_vec, 16));
    check("s_vec_count", 32'(s_vcnt), sat(m_vec, 2));
    check("err_count", 32'(ecnt), sat(m_err, 16));
    check("s_err_count", 32'(s_ecnt), sat(m_err, 2));
    check("done", 32'(done), 32'(m_done));
    check("s_done", 32'(s_done), 32'(m_done));
    check("pass", 32'(pass), 32'(m_pass));
    check("s_pass", 32'(s_pass), 32'(m_pass));
    check("ff_vec", 32'(ffv), 32'(m_ffv));
    check("ff_obs", 32'(ffo), 32'(m_ffo));
    check("s_ff_vec", 32'(s_ffv), 32'(m_ffv));
    check("s_ff_obs", 32'(s_ffo), 32'(m_ffo));
  end

  // Directed scenario bookkeeping: tick index, hand-computed exp values, pulse log.
  logic [4:0] stim_q[$];
  logic [1:0] lit_q[$];
  logic       flt_q[$];
  int t, mis_cnt, first_mis_t, fsteps;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (t >= LAT - 1 && t - (LAT - 1) < lit_q.size())
      check("exp_literal", 32'({exp22, exp23}), 32'(lit_q[t - (LAT - 1)]));
    if (mis) begin
      if (mis_cnt == 0) first_mis_t = t;
      mis_cnt++;
    end
    t++;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_vec_count", 32'(vcnt), 0);
    check("clear_done", 32'(done), 0);
  endtask

  task automatic run_stream(input bit drain_vec, input bit stuck_in, input int e_vec,
                            input int e_err, input bit e_pass, input logic [4:0] e_ffv,
                            input logic [1:0] e_ffo, input int e_mis, input int e_first);
    t = 0; mis_cnt = 0; first_mis_t = -1; stuck = stuck_in;
    for (int j = 0; j < stim_q.size(); j++) begin
      vec_valid = 1'b1; vec = stim_q[j]; fault22 = flt_q[j];
      tick();
    end
    vec_valid = 1'b0; vec = '0; fault22 = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    fsteps = 0;
    while (!done && fsteps < 20) begin
      vec_valid = drain_vec && fsteps == 0;
      vec = (drain_vec && fsteps == 0) ? 5'b11111 : 5'b00000;
      tick();
      fsteps++;
    end
    vec_valid = 1'b0; vec = '0;
    check("done_edges_after_flush", 32'(fsteps), LAT);
    check("stream_done", 32'(done), 1);
    check("stream_vec_count", 32'(vcnt), e_vec);
    check("stream_err_count", 32'(ecnt), e_err);
    check("stream_pass", 32'(pass), 32'(e_pass));
    check("stream_ff_vec", 32'(ffv), CAP ? 32'(e_ffv) : 0);
    check("stream_ff_obs", 32'(ffo), CAP ? 32'(e_ffo) : 0);
    check("stream_mismatch_pulses", 32'(mis_cnt), e_mis);
    check("stream_first_mismatch_tick", 32'(first_mis_t), 32'(e_first));
    tick();
    tick();
    check("done_holds", 32'(done), 1);
    check("count_holds", 32'(vcnt), e_vec);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_done", 32'(done), 0);
    check("reset_mismatch", 32'(mis), 0);
    rst = 1'b0;
    lit_q = {};

    // Golden pass stream.
    stim_q = '{5'b10101, 5'b01010, 5'b10011, 5'b11000, 5'b01101};
    lit_q  = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    flt_q  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_stream(1'b0, 1'b0, 5, 0, 1'b1, 5'b0, 2'b0, 0, -1);
    do_clear();

    // Same stream with N22 forced high on the third vector.
    flt_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    run_stream(1'b0, 1'b0, 5, 1, 1'b0, 5'b10011, 2'b11, 1, 5);
    do_clear();

    // Extremes against a DUT stuck at 11.
    stim_q = '{5'b11111, 5'b00000};
    lit_q  = '{2'b10, 2'b00};
    flt_q  = '{1'b0, 1'b0};
    run_stream(1'b0, 1'b1, 2, 2, 1'b0, 5'b11111, 2'b11, 2, 3);
    do_clear();

    // Drain: a vector offered during DRAIN must be ignored.
    stim_q = '{5'b10101};
    lit_q  = '{2'b11};
    flt_q  = '{1'b0};
    run_stream(1'b1, 1'b0, 1, 0, 1'b1, 5'b0, 2'b0, 0, -1);
    do_clear();

    // Clear before a failing vector reaches its compare edge.
    lit_q = {};
    t = 0; mis_cnt = 0; stuck = 1'b1;
    vec_valid = 1'b1; vec = 5'b11111;
    tick();
    vec_valid = 1'b0; vec = '0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (4) tick();
    check("clear_mid_no_pulse", 32'(mis_cnt), 0);
    check("clear_mid_err", 32'(ecnt), 0);
    check("clear_mid_vec", 32'(vcnt), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("idle_flush_done", 32'(done), 1);
    check("idle_flush_pass", 32'(pass), 1);
    check("idle_flush_vec", 32'(vcnt), 0);
    do_clear();

    // Asynchronous reset mid-cycle while a second failing vector is in flight.
    t = 0; mis_cnt = 0;
    vec_valid = 1'b1; vec = 5'b11111;
    tick();
    vec = 5'b00000;
    tick();
    vec_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_mismatch", 32'(mis), 1);
    check("pre_rst_err", 32'(ecnt), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_mismatch", 32'(mis), 0);
    check("rst_async_err", 32'(ecnt), 0);
    check("rst_async_vec", 32'(vcnt), 0);
    check("rst_async_exp", 32'({exp22, exp23}), 0);
    check("rst_async_ff", 32'({ffv, ffo}), 0);
    @(negedge clk);
    rst = 1'b0;
    mis_cnt = 0;
    repeat (4) tick();
    check("post_rst_no_pulse", 32'(mis_cnt), 0);
    check("post_rst_vec", 32'(vcnt), 0);

    // Saturation: five failing vectors against the narrow-counter instance.
    stim_q = '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111};
    lit_q  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    flt_q  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_stream(1'b0, 1'b1, 5, 5, 1'b0, 5'b11111, 2'b11, 5, 3);
    check("sat_small_err", 32'(s_ecnt), 3);
    check("sat_small_vec", 32'(s_vcnt), 3);
    check("sat_small_pass", 32'(s_pass), 0);
    do_clear();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/c17_pipe_checker.md
Name: c17_pipe_checker

Overview:
- Self-checking response monitor for the bit-level pipelined c17 netlists (c17_s1/s2/s3).
- Taps the vector applied at the DUT inputs and computes the golden c17 response.
- Delays the golden response by the DUT pipeline latency, then compares it against the DUT N22/N23 outputs.
- Reports per-vector mismatches, running counts and an overall pass/fail verdict; lets pipelined variants run on the board or in simulation without manual waveform inspection.

Parameters:
- LATENCY, 3, number of DUT clock edges from vector sampling to output sampling; legal range 1..8.
- CNT_W, 16, width of the vector and error counters.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- vec_valid  input  1  N1..N7 carry a new vector this cycle
- N1, N2, N3, N6, N7  input  1 each  vector as driven to the DUT
- dut_N22, dut_N23  input  1 each  DUT outputs
- flush  input  1  end of stimulus; drain the pipeline and issue the verdict
- clear  input  1  synchronous return to IDLE; counters cleared
- exp_N22, exp_N23  output  1 each  golden value currently being compared
- mismatch  output  1  one-cycle pulse per failing vector
- vec_count  output  CNT_W  vectors checked
- err_count  output  CNT_W  vectors failed
- done  output  1  verdict valid
- pass  output  1  done and err_count==0
- ff_vec  output  5  first failing vector {N1,N2,N3,N6,N7}
- ff_obs  output  2  first failing observed {dut_N22,dut_N23}

Behaviour:
- Reset: all outputs 0, state IDLE, delay line valid bits all 0.
- Golden function: N10=~(N1&N3); N11=~(N3&N6); N16=~(N2&N11); N19=~(N11&N7); N22=~(N10&N16); N23=~(N16&N19).
- Delay line:
  - Entry 0 loads {valid, N22, N23} at each edge where vec_valid=1 and state is IDLE or RUN; otherwise it loads valid=0.
  - Entries shift every edge; depth is LATENCY.
- Compare alignment:
  - A vector sampled at edge k is compared with dut_N22/dut_N23 sampled at edge k+LATENCY.
  - mismatch is high in the cycle after edge k+LATENCY.
  - exp_N22/exp_N23 show the tail entry combinationally (registered tail, no logic after it).
- Counters: at a compare edge with a valid tail, vec_count increments; err_count also increments on mismatch. Both saturate at all-ones.
- FSM:
  - IDLE -> RUN on first accepted vec_valid.
  - RUN -> DRAIN on flush.
  - DRAIN -> DONE when all delay-line valid bits are 0; done rises the same edge.
  - DONE holds outputs until clear or rst.
- vec_valid during DRAIN or DONE is ignored (not loaded, not counted).
- flush in IDLE moves directly to DONE with pass=1 and vec_count=0.
- Simultaneous events:
  - clear beats flush and vec_valid.
  - clear in any state: counters, ff_*, done and pass go to 0 and the delay line is invalidated at that edge; state becomes IDLE.
  - A compare and a clear at the same edge: clear wins and the compare is discarded.
- rst mid-operation discards in-flight vectors immediately; no mismatch pulse is produced.

Optional Feature:
- Macro: C17_CHK_CAPTURE_EN
- Defined:
  - On the first mismatch after reset/clear, latch ff_vec (the vector carried alongside the delay line) and ff_obs.
  - Hold both until clear/rst.
  - The delay line widens by 5 bits to carry the vector.
- Undefined: ff_vec and ff_obs are tied to 0, the delay line carries no vector bits, and the ports remain present.

Test Plan:
- Golden pass stream: rst, then five consecutive vectors 10101, 01010, 10011, 11000, 01101 with a correct LATENCY=3 model. Required expected outputs are 11, 11, 01, 11, 11 ({N22,N23}). Then flush -> vec_count=5, err_count=0, mismatch never high, done=1, pass=1.
- Single fault: same stream with dut_N22 forced 1 for the third vector only -> exactly one mismatch pulse, 4 cycles after that vector's vec_valid edge (k+LATENCY, seen in the following cycle). After flush: err_count=1, pass=0. With C17_CHK_CAPTURE_EN: ff_vec=10011, ff_obs=11.
- Extremes: vectors 11111 then 00000 -> expected {N22,N23} 10 then 00. A DUT stuck at 11 gives err_count=2; the first capture is ff_vec=11111, ff_obs=11.
- Drain and ignore: flush asserted the cycle after the last vector, with vec_valid=1 (vector 11111) during DRAIN -> the in-flight vector is still checked. The DRAIN vector is not counted (vec_count=1), and done rises exactly LATENCY edges after flush.
- Clear/reset mid-run: clear two cycles after a failing vector, before its compare edge -> no mismatch pulse, counters 0, state IDLE. Repeat with rst pulsed asynchronously mid-cycle -> all outputs 0 immediately.
- Boundaries: flush from IDLE -> done=1, pass=1 after one edge. With CNT_W=2, run 5 failing vectors -> err_count saturates at 3.
